// File: rtl/cache_req_queue.sv
// Request FIFO in front of a single-outstanding cache port.
// Requests are popped in order, issued as a one-cycle strobe, and completed with a one-cycle response.
module cache_req_queue #(
  parameter int WIDTH       = 8,
  parameter int RAM_DEPTH   = 256,
  parameter int QUEUE_DEPTH = 4,
  localparam int AW         = $clog2(RAM_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic             rsp_we,
  output logic [WIDTH-1:0] rsp_data,
  output logic             cache_we,
  output logic             cache_re,
  output logic [AW-1:0]    cache_addr,
  output logic [WIDTH-1:0] cache_data_in,
  input  logic             cache_done,
  input  logic [WIDTH-1:0] cache_data_out,
  output logic             busy
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  typedef struct packed {
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
  } req_t;

  req_t             fifo_q [QUEUE_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [1:0]       state;
  req_t             iss_q;
  logic [WIDTH-1:0] rdata_q;
  logic             push, pop;

  // Ready comes from registered count only, so a pop never frees a slot in the same cycle.
  assign req_ready = count < CW'(QUEUE_DEPTH);
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && (count != '0);

  // Storage needs no reset; count/pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{we: req_we, addr: req_addr, wdata: req_wdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state   <= S_IDLE;
      iss_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case (state)
        S_IDLE: begin
          if (pop) begin
            iss_q <= fifo_q[rd_ptr];
            state <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (cache_done) begin
            rdata_q <= iss_q.we ? '0 : cache_data_out;
            state   <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cache_we      = (state == S_ISSUE) &&  iss_q.we;
  assign cache_re      = (state == S_ISSUE) && !iss_q.we;
  assign cache_addr    = (state != S_IDLE) ? iss_q.addr  : '0;
  assign cache_data_in = (state != S_IDLE) ? iss_q.wdata : '0;
  assign rsp_valid     = (state == S_RESP);
  assign rsp_we        = (state == S_RESP) && iss_q.we;
  assign rsp_data      = (state == S_RESP) ? rdata_q : '0;
  assign busy          = (state != S_IDLE) || (count != '0);
endmodule

// File: tb/tb_cache_req_queue.sv
// Directed bench for cache_req_queue: cycle table for single write/read/stray-done,
// plus hand sequences for fill, reset in WAIT and push/pop at the same edge.
module tb_cache_req_queue;
  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_we;
  logic [7:0] rsp_data;
  logic       cache_we, cache_re;
  logic [7:0] cache_addr, cache_data_in;
  logic       cache_done;
  logic [7:0] cache_data_out;
  logic       busy;

  int total = 0;
  int bad   = 0;

  cache_req_queue #(.WIDTH(8), .RAM_DEPTH(256), .QUEUE_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_data(rsp_data),
    .cache_we(cache_we), .cache_re(cache_re), .cache_addr(cache_addr),
    .cache_data_in(cache_data_in), .cache_done(cache_done),
    .cache_data_out(cache_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // {ready, busy, cache_we, cache_re, cache_addr, cache_data_in, rsp_valid, rsp_we, rsp_data}
  typedef struct packed {
    logic [2:0] ctl;    // {rst, req_valid, req_we}
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       done;
    logic [7:0] dout;
    logic [29:0] exp;
  } vec_t;

  function automatic logic [29:0] ex(input logic [3:0] fl, input logic [7:0] ca,
                                     input logic [7:0] cd, input logic [1:0] rs,
                                     input logic [7:0] rd);
    return {fl, ca, cd, rs, rd};
  endfunction

  function automatic vec_t mk(input logic [2:0] ctl, input logic [7:0] a, input logic [7:0] d,
                              input logic dn, input logic [7:0] dout, input logic [29:0] e);
    vec_t v;
    v.ctl = ctl; v.addr = a; v.wdata = d; v.done = dn; v.dout = dout; v.exp = e;
    return v;
  endfunction

  function automatic logic [29:0] obs();
    return {req_ready, busy, cache_we, cache_re, cache_addr, cache_data_in,
            rsp_valid, rsp_we, rsp_data};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [7:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 1'b0; cache_done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Waits (bounded) for the issue strobe of the next request, then completes it.
  task automatic serve(input string nm, input logic we, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] dout);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(cache_we || cache_re) && n < 20);
    chk({nm, " strobe"}, 32'({cache_we, cache_re, cache_addr, cache_data_in}),
        32'({we, ~we, a, d}));
    tick();
    cache_done = 1'b1; cache_data_out = dout;
    tick();
    cache_done = 1'b0;
    chk({nm, " rsp"}, 32'({rsp_valid, rsp_we, rsp_data, cache_addr}),
        32'({1'b1, we, (we ? 8'h00 : dout), a}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    cache_done = 1'b0; cache_data_out = 8'h00;

    // Single write, 3 WAIT cycles, done carries junk data that must not reach rsp_data
    tbl.push_back(mk(3'b100, 8'h00, 8'h00, 1'b0, 8'h00, ex(4'b1000, 8'h00, 8'h00, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b011, 8'h12, 8'hA5, 1'b0, 8'h00, ex(4'b1100, 8'h00, 8'h00, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b0, 8'h00, ex(4'b1110, 8'h12, 8'hA5, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b0, 8'h00, ex(4'b1100, 8'h12, 8'hA5, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b0, 8'h00, ex(4'b1100, 8'h12, 8'hA5, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b0, 8'h00, ex(4'b1100, 8'h12, 8'hA5, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b1, 8'hFF, ex(4'b1100, 8'h12, 8'hA5, 2'b11, 8'h00)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b0, 8'h00, ex(4'b1000, 8'h00, 8'h00, 2'b00, 8'h00)));
    // Read back
    tbl.push_back(mk(3'b010, 8'h12, 8'h00, 1'b0, 8'h00, ex(4'b1100, 8'h00, 8'h00, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b0, 8'h00, ex(4'b1101, 8'h12, 8'h00, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b0, 8'h00, ex(4'b1100, 8'h12, 8'h00, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b1, 8'hA5, ex(4'b1100, 8'h12, 8'h00, 2'b10, 8'hA5)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b0, 8'h00, ex(4'b1000, 8'h00, 8'h00, 2'b00, 8'h00)));
    // Stray done in IDLE (empty and non-empty) and in ISSUE
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b1, 8'h55, ex(4'b1000, 8'h00, 8'h00, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b010, 8'h34, 8'h00, 1'b1, 8'h55, ex(4'b1100, 8'h00, 8'h00, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b1, 8'h55, ex(4'b1101, 8'h34, 8'h00, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b1, 8'h55, ex(4'b1100, 8'h34, 8'h00, 2'b00, 8'h00)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b1, 8'h66, ex(4'b1100, 8'h34, 8'h00, 2'b10, 8'h66)));
    tbl.push_back(mk(3'b000, 8'h00, 8'h00, 1'b0, 8'h00, ex(4'b1000, 8'h00, 8'h00, 2'b00, 8'h00)));

    for (int i = 0; i < tbl.size(); i++) begin
      {rst, req_valid, req_we} = tbl[i].ctl;
      req_addr = tbl[i].addr; req_wdata = tbl[i].wdata;
      cache_done = tbl[i].done; cache_data_out = tbl[i].dout;
      tick();
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
    end

    // Fill: 5 back-to-back writes with done withheld -> 1 in flight + 4 queued
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push(1'b1, 8'(k), 8'(8'h10 + k));
      tick();
      chk($sformatf("fill ready%0d", k), 32'(req_ready), 32'(k < 4));
    end
    req_valid = 1'b0;
    tick();
    chk("fill ready held", 32'({req_ready, busy}), 32'(2'b01));
    cache_done = 1'b1;
    tick();
    cache_done = 1'b0;
    chk("fill0 rsp", 32'({rsp_valid, rsp_we, rsp_data, cache_addr}), 32'({2'b11, 8'h00, 8'h00}));
    for (int k = 1; k < 5; k++)
      serve($sformatf("fill%0d", k), 1'b1, 8'(k), 8'(8'h10 + k), 8'hEE);
    tick();
    tick();
    chk("fill drained", 32'({req_ready, busy}), 32'(2'b10));

    // Reset while WAIT with two queued; the request presented during reset is dropped
    do_reset();
    push(1'b0, 8'h40, 8'h00); tick();
    push(1'b0, 8'h41, 8'h00); tick();
    push(1'b0, 8'h42, 8'h00); tick();
    rst = 1'b1; push(1'b0, 8'h43, 8'h00);
    tick();
    chk("rst wait", 32'({busy, req_ready, rsp_valid, cache_we, cache_re}), 32'(5'b01000));
    rst = 1'b0; req_valid = 1'b0; cache_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rst after%0d", k),
          32'({busy, req_ready, rsp_valid, cache_we, cache_re, cache_addr}),
          32'({5'b01000, 8'h00}));
    end
    cache_done = 1'b0;

    // Push and pop on the same edge at count=2
    do_reset();
    push(1'b0, 8'h20, 8'h00); tick();
    push(1'b0, 8'h21, 8'h00); tick();
    push(1'b0, 8'h22, 8'h00); tick();
    req_valid = 1'b0;
    cache_done = 1'b1; cache_data_out = 8'hA0;
    tick();
    cache_done = 1'b0;
    chk("pp A rsp", 32'({rsp_valid, rsp_data, cache_addr}), 32'({1'b1, 8'hA0, 8'h20}));
    tick();
    push(1'b0, 8'h23, 8'h00);
    tick();
    chk("pp B issue", 32'({cache_re, cache_addr, req_ready}), 32'({1'b1, 8'h21, 1'b1}));
    push(1'b0, 8'h24, 8'h00);
    tick();
    chk("pp count3 ready", 32'(req_ready), 32'(1'b1));
    push(1'b0, 8'h25, 8'h00);
    tick();
    chk("pp count4 ready", 32'(req_ready), 32'(1'b0));
    req_valid = 1'b0;
    cache_done = 1'b1; cache_data_out = 8'hB1;
    tick();
    cache_done = 1'b0;
    chk("pp B rsp", 32'({rsp_valid, rsp_data, cache_addr}), 32'({1'b1, 8'hB1, 8'h21}));
    serve("pp C", 1'b0, 8'h22, 8'h00, 8'hC2);
    serve("pp D", 1'b0, 8'h23, 8'h00, 8'hD3);
    serve("pp E", 1'b0, 8'h24, 8'h00, 8'hE4);
    serve("pp F", 1'b0, 8'h25, 8'h00, 8'hF5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
